// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: signed PCM to 1-bit pulse-density stream with soft-start.
// Order 1 is a carry-out accumulator; order 2 uses two saturating integrators.
module sigma_delta_dac #(
  parameter int signalwidth = 16,
  parameter int order       = 1,
  parameter int rampshift   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ena,
  input  logic [signalwidth-1:0] d,
  output logic                   q,
  output logic                   ready
);
  localparam int SW = signalwidth;
  localparam int PW = (rampshift > 0) ? rampshift : 1;
  localparam logic [SW-1:0] LVL_MIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic {RAMP, RUN} state_e;

  state_e        state_q;
  logic [SW-1:0] level_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          q_d;

  assign tick = (rampshift == 0) || (presc_q == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RAMP;
      ready   <= 1'b0;
      level_q <= LVL_MIN;
      presc_q <= '0;
    end else begin
      unique case (state_q)
        RAMP: begin
          presc_q <= presc_q + PW'(1);
          if (tick) begin
            if (level_q == '1) begin
              level_q <= '0;
              state_q <= RUN;
              ready   <= 1'b1;
            end else begin
              level_q <= level_q + SW'(1);
            end
          end
        end
        RUN: begin
          if (ena) level_q <= d;
        end
      endcase
    end
  end

  generate
    if (order == 1) begin : gen_o1
      logic [SW-1:0] acc_q;
      logic [SW:0]   sum;

      // Offset-binary view of level: MSB flipped.
      assign sum = {1'b0, acc_q}
                 + {1'b0, ~level_q[SW-1], level_q[SW-2:0]};
      assign q_d = sum[SW];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= sum[SW-1:0];
      end
    end else begin : gen_o2
      localparam int W1 = SW + 2;
      localparam int W2 = SW + 4;
      localparam logic [W1:0] FB1 = {3'b000, 1'b1, {(SW-1){1'b0}}};
      localparam logic [W2:0] FB2 = {5'b00000, 1'b1, {(SW-1){1'b0}}};

      logic [W1-1:0] i1_q;
      logic [W1-1:0] i1n;
      logic [W2-1:0] i2_q;
      logic [W2-1:0] i2n;
      logic [W1:0]   x1;
      logic [W1:0]   fb1;
      logic [W1:0]   s1;
      logic [W2:0]   fb2;
      logic [W2:0]   s2;

      assign x1  = {{3{level_q[SW-1]}}, level_q};
      assign fb1 = q ? FB1 : -FB1;
      assign fb2 = q ? FB2 : -FB2;

      // One guard bit per sum; a guard/sign mismatch means clip.
      assign s1 = {i1_q[W1-1], i1_q} + x1 - fb1;

      always_comb begin
        i1n = s1[W1-1:0];
        if (s1[W1] != s1[W1-1])
          i1n = {s1[W1], {(W1-1){~s1[W1]}}};
      end

      assign s2 = {i2_q[W2-1], i2_q}
                + {{3{i1n[W1-1]}}, i1n} - fb2;

      always_comb begin
        i2n = s2[W2-1:0];
        if (s2[W2] != s2[W2-1])
          i2n = {s2[W2], {(W2-1){~s2[W2]}}};
      end

      assign q_d = ~i2n[W2-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          i1_q <= '0;
          i2_q <= '0;
        end else begin
          i1_q <= i1n;
          i2_q <= i2n;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= q_d;
  end

endmodule
